// File: rtl/drum_seq_divider.sv
// drum_seq_divider
// Sequential DRUM-style approximate divider, the counterpart of the DRUM
// approximate multiplier.
//
// Each operand is cut down to a K-bit leading-one window. When bits are
// dropped, the window LSB is forced to 1 so the truncation is unbiased. The
// two windows are divided by a restoring divider that produces one bit per
// cycle. The quotient is then shifted back by the difference of the two
// window exponents.
//
// Ports
//    clk          clock, rising edge
//    rst_n        asynchronous active-low reset
//    in_valid     operands presented
//    in_ready     block idle and able to accept operands
//    dividend     2*SIZE-bit unsigned dividend
//    divisor      SIZE-bit unsigned divisor
//    out_valid    result valid, held until taken
//    out_ready    consumer takes the result
//    quotient     SIZE-bit approximate quotient
//    sat          result overflowed SIZE bits and was clamped to all-ones
//    div_by_zero  divisor was zero, quotient forced to all-ones
module drum_seq_divider #(
   parameter int SIZE = 8,
   parameter int K    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*SIZE-1:0] dividend,
   input  logic [SIZE-1:0]   divisor,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SIZE-1:0]   quotient,
   output logic              sat,
   output logic              div_by_zero
);

   localparam int PW = $clog2(2*SIZE);
   localparam int NW = PW + 2;
   localparam int CW = $clog2(2*K);
   localparam int RW = 2*K + 2*SIZE;

   typedef enum logic [2:0] {IDLE, NORM, DIV, SCALE, DONE} state_t;

   state_t              state_q, state_d;
   logic [2*SIZE-1:0]   dividend_q, dividend_d;
   logic [SIZE-1:0]     divisor_q, divisor_d;
   logic [K-1:0]        t2_q, t2_d;
   logic [PW-1:0]       s1_q, s1_d;
   logic [PW-1:0]       s2_q, s2_d;
   logic [K-1:0]        rem_q, rem_d;
   logic [2*K-1:0]      nq_q, nq_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [SIZE-1:0]     quotient_q, quotient_d;
   logic                sat_q, sat_d;
   logic                dbz_q, dbz_d;

   logic [K:0]          remShift;
   logic                subOk;
   logic signed [NW-1:0] net;
   logic [NW-1:0]       netMag;
   logic [RW-1:0]       qExt;
   logic [RW-1:0]       scaled;

   function automatic logic [PW-1:0] msbPos(input logic [2*SIZE-1:0] x);
      msbPos = '0;
      for (int i = 0; i < 2*SIZE; i++) begin
         if (x[i]) msbPos = PW'(i);
      end
   endfunction

   function automatic logic [PW-1:0] winShift(input logic [2*SIZE-1:0] x);
      logic [PW-1:0] p;
      p = msbPos(x);
      if (p > PW'(K-1)) winShift = p - PW'(K-1);
      else              winShift = '0;
   endfunction

   // Operands that already fit in K bits are used exactly; larger ones lose
   // their low bits, and the forced LSB stands in for the discarded tail.
   function automatic logic [K-1:0] winValue(input logic [2*SIZE-1:0] x);
      logic [PW-1:0]     s;
      logic [2*SIZE-1:0] sh;
      s  = winShift(x);
      sh = x >> s;
      if (s != '0) winValue = sh[K-1:0] | K'(1);
      else         winValue = x[K-1:0];
   endfunction

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quotient_q;
   assign sat         = sat_q;
   assign div_by_zero = dbz_q;

   // One restoring step: bring down the next dividend bit, then subtract the
   // divisor window if it fits. A kept remainder is always below t2, so it
   // fits back into K bits.
   always_comb begin
      remShift = {rem_q, nq_q[2*K-1]};
      subOk    = (remShift >= {1'b0, t2_q});
   end

   // Exponent difference and the rescaled quotient. The extra K in the
   // exponent undoes the 2^K pre-scaling of the dividend window.
   always_comb begin
      net    = $signed({2'b00, s1_q}) - $signed({2'b00, s2_q}) - NW'(K);
      netMag = net[NW-1] ? (~net + 1'b1) : net;
      qExt   = RW'(nq_q);
      scaled = net[NW-1] ? (qExt >> netMag) : (qExt << netMag);
   end

   // Next-state and datapath control for the five-state sequencer.
   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      t2_d       = t2_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      rem_d      = rem_q;
      nq_d       = nq_q;
      cnt_d      = cnt_q;
      quotient_d = quotient_q;
      sat_d      = sat_q;
      dbz_d      = dbz_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               dividend_d = dividend;
               divisor_d  = divisor;
               state_d    = NORM;
            end
         end
         NORM: begin
            s1_d  = winShift(dividend_q);
            s2_d  = winShift({{SIZE{1'b0}}, divisor_q});
            t2_d  = winValue({{SIZE{1'b0}}, divisor_q});
            nq_d  = {winValue(dividend_q), {K{1'b0}}};
            rem_d = '0;
            cnt_d = CW'(2*K-1);
            // Zero operands skip the divide loop. They still pass through
            // SCALE, which is the only place the result registers are written.
            if ((divisor_q == '0) || (dividend_q == '0)) state_d = SCALE;
            else                                         state_d = DIV;
         end
         DIV: begin
            rem_d = subOk ? K'(remShift - {1'b0, t2_q}) : remShift[K-1:0];
            nq_d  = {nq_q[2*K-2:0], subOk};
            if (cnt_q == '0) state_d = SCALE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         SCALE: begin
            if (divisor_q == '0) begin
               quotient_d = '1;
               sat_d      = 1'b0;
               dbz_d      = 1'b1;
            end else if (dividend_q == '0) begin
               quotient_d = '0;
               sat_d      = 1'b0;
               dbz_d      = 1'b0;
            end else if (|scaled[RW-1:SIZE]) begin
               quotient_d = '1;
               sat_d      = 1'b1;
               dbz_d      = 1'b0;
            end else begin
               quotient_d = scaled[SIZE-1:0];
               sat_d      = 1'b0;
               dbz_d      = 1'b0;
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. Reset aborts any operation in flight and
   // clears the visible result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         dividend_q <= '0;
         divisor_q  <= '0;
         t2_q       <= '0;
         s1_q       <= '0;
         s2_q       <= '0;
         rem_q      <= '0;
         nq_q       <= '0;
         cnt_q      <= '0;
         quotient_q <= '0;
         sat_q      <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         t2_q       <= t2_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         rem_q      <= rem_d;
         nq_q       <= nq_d;
         cnt_q      <= cnt_d;
         quotient_q <= quotient_d;
         sat_q      <= sat_d;
         dbz_q      <= dbz_d;
      end
   end

endmodule
